// File: rtl/pwm_frame_sequencer_if.sv
// Control, table-write and frame-output bundle between the PWM frame sequencer
// and its controller / downstream PWM generator.
interface pwm_frame_sequencer_if #(
  parameter int W  = 7,
  parameter int AW = 3,
  parameter int FW = 16
);
  logic [FW-1:0] frame_len;
  logic [AW-1:0] last_idx;
  logic          loop;
  logic          start;
  logic          stop;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [W-1:0]  wr_A;
  logic [W-1:0]  wr_B;
  logic [W-1:0]  A_val;
  logic [W-1:0]  B_val;
  logic          clkZ;
  logic          en;
  logic          busy;
  logic [AW-1:0] idx;
  logic          done;

  modport master (
    output frame_len, last_idx, loop, start, stop, wr_en, wr_addr, wr_A, wr_B,
    input  A_val, B_val, clkZ, en, busy, idx, done
  );

  modport slave (
    input  frame_len, last_idx, loop, start, stop, wr_en, wr_addr, wr_A, wr_B,
    output A_val, B_val, clkZ, en, busy, idx, done
  );
endinterface

// File: rtl/pwm_frame_sequencer.sv
// Frame-rate A/B parameter source: steps through an 8-entry table, one entry per
// frame, and emits the clkZ reload strobe and en for the PWM generator.
module pwm_frame_sequencer #(
  parameter int W     = 7,
  parameter int DEPTH = 8,
  parameter int FW    = 16
) (
  input  logic                 clkCore,
  input  logic                 reset,
  pwm_frame_sequencer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state;
  logic [W-1:0]  tab_a [DEPTH];
  logic [W-1:0]  tab_b [DEPTH];
  logic [FW-1:0] fc;
  logic [FW-1:0] len_s;
  logic [AW-1:0] last_s;
  logic          loop_s;
  logic          stop_pend;
  logic [W-1:0]  a_r, b_r;
  logic [AW-1:0] idx_r, nxt_idx;
  logic          clkz_r, en_r, done_r;

  always_comb begin
    nxt_idx = (idx_r == last_s) ? '0 : idx_r + 1'b1;
  end

  always_ff @(posedge clkCore or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      fc        <= '0;
      len_s     <= '0;
      last_s    <= '0;
      loop_s    <= 1'b0;
      stop_pend <= 1'b0;
      a_r       <= '0;
      b_r       <= '0;
      idx_r     <= '0;
      clkz_r    <= 1'b0;
      en_r      <= 1'b0;
      done_r    <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        tab_a[i] <= '0;
        tab_b[i] <= '0;
      end
    end else begin
      done_r <= 1'b0;
      // Loads below read the pre-write contents, so a same-cycle write lands next pass.
      if (bus.wr_en) begin
        tab_a[bus.wr_addr] <= bus.wr_A;
        tab_b[bus.wr_addr] <= bus.wr_B;
      end
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            state     <= RUN;
            len_s     <= bus.frame_len;
            last_s    <= bus.last_idx;
            loop_s    <= bus.loop;
            stop_pend <= 1'b0;
            fc        <= '0;
            idx_r     <= '0;
            a_r       <= tab_a[0];
            b_r       <= tab_b[0];
            clkz_r    <= 1'b1;
            en_r      <= 1'b1;
          end
        end
        RUN: begin
          if (fc == len_s) begin
            fc <= '0;
            if (stop_pend || bus.stop || (idx_r == last_s && !loop_s)) begin
              state     <= IDLE;
              stop_pend <= 1'b0;
              clkz_r    <= 1'b0;
              en_r      <= 1'b0;
              done_r    <= 1'b1;
            end else begin
              idx_r  <= nxt_idx;
              a_r    <= tab_a[nxt_idx];
              b_r    <= tab_b[nxt_idx];
              clkz_r <= 1'b1;
            end
          end else begin
            fc     <= fc + 1'b1;
            clkz_r <= 1'b0;
            if (bus.stop) stop_pend <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.A_val = a_r;
  assign bus.B_val = b_r;
  assign bus.idx   = idx_r;
  assign bus.clkZ  = clkz_r;
  assign bus.en    = en_r;
  assign bus.busy  = en_r;
  assign bus.done  = done_r;
endmodule

// File: doc/pwm_frame_sequencer.md
# pwm_frame_sequencer

Frame-rate parameter source that sits directly upstream of the PWM generator. Holds an 8-entry table of (A, B) count pairs and emits the frame strobe `clkZ` on which the generator's counters reload. Presents one table entry per frame on `A_val`/`B_val`, stepping through entries 0..`last_idx` once or in a loop. Also drives the generator's `en`.

## Interface
- `W`, 7, width of the A/B count values.
- `DEPTH`, 8, number of table entries; index width is `AW = log2(DEPTH)` = 3.
- `FW`, 16, width of the frame-length field.

- `clkCore`  in  1  core clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high; clears the table, state and all outputs.
- `frame_len`  in  FW  frame period minus one, in `clkCore` cycles; sampled on accepted `start`.
- `last_idx`  in  AW  last table entry played; sampled on accepted `start`.
- `loop`  in  1  1 = wrap from `last_idx` to entry 0 indefinitely; sampled on accepted `start`.
- `start`  in  1  single-cycle request to begin playback.
- `stop`  in  1  single-cycle request to end playback at the next frame boundary.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  AW  table write index.
- `wr_A`, `wr_B`  in  W  table write data.
- `A_val`, `B_val`  out  W  registered A/B values of the current frame.
- `clkZ`  out  1  one-cycle frame strobe, high on the first cycle of each frame.
- `en`  out  1  high while playing.
- `busy`  out  1  equals `en`.
- `idx`  out  AW  table index currently on `A_val`/`B_val`.
- `done`  out  1  one-cycle pulse when playback ends.

## Operation
- States: IDLE and RUN. Internals are a frame counter `fc` (FW bits), latched `len_s`/`last_s`/`loop_s`, and a `stop_pend` flag.
- Reset state:
  - State is IDLE; all table entries are 0.
  - `A_val`, `B_val`, `idx`, `clkZ`, `en`, `busy`, `done` and `stop_pend` are 0.
- IDLE:
  - `start`=1 with `stop`=0 → RUN. Latch `len_s`, `last_s` and `loop_s`; set `fc`=0, `idx`=0 and load table[0] into `A_val`/`B_val`.
  - `start` and `stop` in the same cycle: `stop` wins and the block stays in IDLE.
  - `A_val`/`B_val`/`idx` hold their last values in IDLE.
- RUN:
  - `fc` counts 0..`len_s`. `clkZ` = 1 exactly when `fc`=0.
  - End of frame is `fc`=`len_s`. On that edge `fc` returns to 0.
  - At end of frame with `stop_pend`=1, or with `idx`=`last_s` and `loop_s`=0: go to IDLE, pulse `done`, clear `stop_pend`.
  - Otherwise, at end of frame: `idx` ← (`idx`=`last_s` ? 0 : `idx`+1), and load the new entry into `A_val`/`B_val`.
  - `stop` sets `stop_pend`. A `stop` arriving on the end-of-frame cycle ends playback at that boundary.
  - `start` is ignored in RUN.
- Table writes are accepted in any state.
  - A load in the same cycle as a write to the same index takes the old contents.
  - The new value appears the next time that entry is loaded.
  - A running frame's `A_val`/`B_val` never change mid-frame.
- `frame_len`=0: every cycle is a frame and `clkZ` stays high for the whole RUN.
- `idx` wraps naturally modulo DEPTH. `last_idx`=0 plays entry 0 only.

## Timing
- `start` sampled at edge t → from cycle t+1: RUN, `en`=1, `clkZ`=1, `A_val`=table[0].
- Frame period P = `len_s`+1 cycles. `clkZ` is high at cycles t+1+k·P.
- `A_val`/`B_val` change on the same edge that raises `clkZ`. They are stable from that edge for the full frame, so downstream sees valid values at the strobe.
- Non-loop completion: `done`=1 and `en`=0 at cycle t+1+(`last_s`+1)·P. `clkZ` stays 0 in that cycle.
- Stop latency: at most one frame. The current frame always completes in full.
- Async `reset` mid-RUN: all outputs go to 0 immediately and the table clears. Playback needs a new `start` and a table reload.

## Test plan
- Reset sequence: assert `reset` mid-RUN → all outputs 0 in the same cycle; after release, the table reads 0 on the next `start`.
- One-shot: table[0..2] = (10,3), (20,5), (30,7); `frame_len`=9, `last_idx`=2, `loop`=0; `start` at t.
  - → `clkZ` high at t+1, t+11, t+21, with `A_val` 10/20/30 and `B_val` 3/5/7.
  - → `done` at t+31 and `en` low from t+31.
- Loop with stop: same table, `loop`=1; `stop` at t+25.
  - → sequence 0,1,2; the frame holding entry 2 completes; `done` at t+31.
  - Repeat with no stop → `idx` wraps to 0 at t+31 and `A_val`=10.
- Write hazard: `wr_en` to index 1 with (99,1) in the same cycle entry 1 loads → that frame shows (20,5). The next loop pass shows (99,1).
- Corner cases:
  - `start`+`stop` together in IDLE → stays IDLE, no `clkZ`.
  - `frame_len`=0, `last_idx`=0, `loop`=0 → exactly one `clkZ` cycle, then `done`.
  - `start` during RUN → no effect on `idx`/`fc`.
